// File: rtl/sf_dft_accum_mc.sv
// Multi-channel single-frequency DFT accumulator: correlates NCH sample streams
// against a loadable cos/sin table and drains one complex bin per channel per frame.
module sf_dft_accum_mc #(
  parameter int NCH          = 2,
  parameter int X_WIDTH      = 16,
  parameter int W_WIDTH      = 16,
  parameter int S_WIDTH      = 38,
  parameter int FRAME_LENGTH = 33,
  parameter int A_WIDTH      = $clog2(FRAME_LENGTH)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 w_we,
  input  logic [A_WIDTH-1:0]                   w_addr,
  input  logic [W_WIDTH-1:0]                   w_cos,
  input  logic [W_WIDTH-1:0]                   w_sin,
  input  logic                                 i_clr,
  input  logic                                 i_vld,
  input  logic [NCH*X_WIDTH-1:0]               i_x,
  output logic                                 o_vld,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] o_ch,
  output logic                                 o_last,
  output logic [S_WIDTH-1:0]                   o_re,
  output logic [S_WIDTH-1:0]                   o_im,
  output logic                                 o_ovf
);

  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int P_W  = X_WIDTH + W_WIDTH;

  typedef enum logic {IDLE, DRAIN} state_t;

  logic signed [W_WIDTH-1:0] cos_mem [FRAME_LENGTH];
  logic signed [W_WIDTH-1:0] sin_mem [FRAME_LENGTH];

  logic [A_WIDTH-1:0]        cnt;
  logic                      s1_vld, s1_first, s1_last;
  logic signed [X_WIDTH-1:0] s1_x [NCH];
  logic signed [W_WIDTH-1:0] s1_cos, s1_sin;

  logic                      s2_vld, s2_first, s2_last;
  logic signed [P_W-1:0]     s2_pre [NCH];
  logic signed [P_W-1:0]     s2_pim [NCH];

  logic                      s3_done;
  logic signed [S_WIDTH-1:0] acc_re [NCH];
  logic signed [S_WIDTH-1:0] acc_im [NCH];

  logic signed [S_WIDTH-1:0] snap_re [NCH];
  logic signed [S_WIDTH-1:0] snap_im [NCH];
  state_t                    state;
  logic [CH_W-1:0]           ptr;

  // Weight table is deliberately outside reset so coefficients survive rst.
  always_ff @(posedge clk) begin
    if (w_we && (int'(w_addr) < FRAME_LENGTH)) begin
      cos_mem[w_addr] <= w_cos;
      sin_mem[w_addr] <= w_sin;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      s1_vld   <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_cos   <= '0;
      s1_sin   <= '0;
      for (int unsigned c = 0; c < NCH; c++) s1_x[c] <= '0;
    end else begin
      s1_vld   <= i_vld && !i_clr;
      s1_first <= (cnt == '0);
      s1_last  <= (cnt == A_WIDTH'(FRAME_LENGTH - 1));
      s1_cos   <= cos_mem[cnt];
      s1_sin   <= sin_mem[cnt];
      for (int unsigned c = 0; c < NCH; c++) s1_x[c] <= i_x[c*X_WIDTH +: X_WIDTH];
      if (i_clr)
        cnt <= '0;
      else if (i_vld)
        cnt <= (cnt == A_WIDTH'(FRAME_LENGTH - 1)) ? '0 : cnt + A_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_vld   <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      for (int unsigned c = 0; c < NCH; c++) begin
        s2_pre[c] <= '0;
        s2_pim[c] <= '0;
      end
    end else begin
      s2_vld   <= s1_vld && !i_clr;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      for (int unsigned c = 0; c < NCH; c++) begin
        s2_pre[c] <= P_W'(s1_x[c]) * P_W'(s1_cos);
        s2_pim[c] <= P_W'(s1_x[c]) * P_W'(s1_sin);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_done <= 1'b0;
      for (int unsigned c = 0; c < NCH; c++) begin
        acc_re[c] <= '0;
        acc_im[c] <= '0;
      end
    end else begin
      s3_done <= s2_vld && s2_last && !i_clr;
      if (s2_vld && !i_clr) begin
        for (int unsigned c = 0; c < NCH; c++) begin
          acc_re[c] <= s2_first ? S_WIDTH'(s2_pre[c])  : acc_re[c] + S_WIDTH'(s2_pre[c]);
          acc_im[c] <= s2_first ? -S_WIDTH'(s2_pim[c]) : acc_im[c] - S_WIDTH'(s2_pim[c]);
        end
      end
    end
  end

  // Channel 0 is emitted straight from the accumulators on the snapshot edge;
  // the buffer then feeds channels 1..NCH-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      o_vld  <= 1'b0;
      o_ch   <= '0;
      o_last <= 1'b0;
      o_re   <= '0;
      o_im   <= '0;
      o_ovf  <= 1'b0;
      for (int unsigned c = 0; c < NCH; c++) begin
        snap_re[c] <= '0;
        snap_im[c] <= '0;
      end
    end else if (s3_done && !i_clr) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        snap_re[c] <= acc_re[c];
        snap_im[c] <= acc_im[c];
      end
      if (state == DRAIN) o_ovf <= 1'b1;
      o_vld  <= 1'b1;
      o_ch   <= '0;
      o_last <= (NCH == 1);
      o_re   <= acc_re[0];
      o_im   <= acc_im[0];
      ptr    <= CH_W'(1);
      state  <= (NCH > 1) ? DRAIN : IDLE;
    end else begin
      case (state)
        DRAIN: begin
          o_vld  <= 1'b1;
          o_ch   <= ptr;
          o_re   <= snap_re[ptr];
          o_im   <= snap_im[ptr];
          o_last <= (ptr == CH_W'(NCH - 1));
          if (ptr == CH_W'(NCH - 1))
            state <= IDLE;
          else
            ptr <= ptr + CH_W'(1);
        end
        default: begin
          o_vld  <= 1'b0;
          o_last <= 1'b0;
        end
      endcase
    end
  end

endmodule
